dump_sequencer: RTL and testbench
=================================

DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 16: number of channels, power of two, >= 2.
REQ-002 SHALL have parameter ARM_CYC, default 2: arm_o high time in cycles, >= 1.
REQ-003 SHALL have parameter DUMP_CYC, default 2: dump_o high time per dump in cycles, >= 1.
REQ-004 SHALL have parameter GAP_CYC, default 1: dump_o low time between dumps in cycles, >= 1.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start_i, input, 1: frame request; sampled in IDLE only.
REQ-008 SHALL have port ch_mask_i, input, N_CH: channels to serve this frame; captured with start_i.
REQ-009 SHALL have port abort_i, input, 1: terminate current frame.
REQ-010 SHALL have port cycle_done_i, input, 1: responder reports all latched channels served.
REQ-011 SHALL have port ch_sel_i, input, N_CH: responder one-hot channel select, valid while dump_o high.
REQ-012 SHALL have port ch_sel_o, output, N_CH: captured mask presented to responder.
REQ-013 SHALL have port arm_o, output, 1: arm strobe to responder.
REQ-014 SHALL have port dump_o, output, 1: dump strobe to responder.
REQ-015 SHALL have port inter_o, output, 1: one-cycle pulse on abort.
REQ-016 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-017 SHALL have port frame_done_o, output, 1: one-cycle pulse on normal frame completion.
REQ-018 SHALL have port served_o, output, N_CH: accumulated channels reported by ch_sel_i this frame.
REQ-019 SHALL have port err_o, output, 1: sticky protocol error flag.

Function
REQ-020 SHALL implement states IDLE, ARM, DUMP_HI, DUMP_GAP, DONE; all outputs registered.
REQ-021 IDLE: start_i=1 with ch_mask_i!=0 SHALL capture mask into ch_sel_o, clear served_o, clear err_o, go ARM next edge.
REQ-022 IDLE: start_i=1 with ch_mask_i==0 SHALL go DONE directly (no arm/dump), served_o cleared.
REQ-023 start_i SHALL be ignored in all states except IDLE; ch_sel_o SHALL hold constant from capture until next capture.
REQ-024 ARM: arm_o=1 for exactly ARM_CYC cycles, then DUMP_HI.
REQ-025 DUMP_HI: dump_o=1 for exactly DUMP_CYC cycles, then DUMP_GAP; dump counter increments on entry (width clog2(N_CH)+2).
REQ-026 ch_sel_i SHALL be sampled on the last DUMP_HI cycle: if one-hot, within ch_sel_o and not already in served_o, OR into served_o; otherwise set err_o.
REQ-027 DUMP_GAP: dump_o=0 for exactly GAP_CYC cycles; on last cycle cycle_done_i=1 -> DONE, else -> DUMP_HI.
REQ-028 Watchdog: leaving DUMP_GAP with cycle_done_i=0 and dump counter == N_CH+1 SHALL set err_o and go IDLE without frame_done_o.
REQ-029 DONE: frame_done_o=1 for one cycle; if served_o != ch_sel_o set err_o; go IDLE next edge.
REQ-030 abort_i=1 in any non-IDLE state SHALL go IDLE next edge, drop arm_o/dump_o that edge, pulse inter_o one cycle, no frame_done_o; served_o retained.
REQ-031 abort_i SHALL win over every other transition in the same cycle; abort_i in IDLE SHALL have no effect.
REQ-032 err_o SHALL stay 1 until rst_i or an accepted start_i.
REQ-033 arm_o and dump_o SHALL never be high simultaneously.

Reset
REQ-034 rst_i=1 at a rising edge SHALL force IDLE, counters 0, and arm_o, dump_o, inter_o, busy_o, frame_done_o, err_o =0, ch_sel_o and served_o =0, overriding abort_i/start_i.
REQ-035 rst_i asserted mid-frame SHALL abandon the frame with no inter_o or frame_done_o pulse.

Verification (N_CH=4, ARM_CYC=2, DUMP_CYC=2, GAP_CYC=1)
REQ-036 start_i, ch_mask_i=4'b1010; model returns 0010 then 1000, cycle_done_i after 2nd dump -> arm_o 2 cycles, 2 dump pulses of 2 cycles, served_o=1010, frame_done_o one pulse, err_o=0.
REQ-037 start_i, ch_mask_i=0 -> no arm_o/dump_o, frame_done_o pulse 2 cycles after start, served_o=0.
REQ-038 mask 4'b0011, model returns 0001 twice -> err_o=1 at 2nd sample, persists after frame_done_o, cleared by next start_i.
REQ-039 mask 4'b1111, cycle_done_i held 0 -> 5 dump pulses then IDLE, err_o=1, no frame_done_o.
REQ-040 abort_i during 1st dump pulse -> dump_o 0 next cycle, inter_o one pulse, busy_o 0, start_i during abort cycle ignored.
REQ-041 rst_i during DUMP_GAP -> all outputs 0 next cycle; subsequent start_i with 4'b0100 completes normally.

Source files
------------

// File: rtl/dump_sequencer.sv
// Dump sequencer: arms a responder, issues timed dump strobes and accumulates
// the channels it reports until the frame completes, aborts or times out.
module dump_sequencer #(
  parameter int N_CH     = 16,
  parameter int ARM_CYC  = 2,
  parameter int DUMP_CYC = 2,
  parameter int GAP_CYC  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [N_CH-1:0] ch_mask_i,
  input  logic            abort_i,
  input  logic            cycle_done_i,
  input  logic [N_CH-1:0] ch_sel_i,
  output logic [N_CH-1:0] ch_sel_o,
  output logic            arm_o,
  output logic            dump_o,
  output logic            inter_o,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic [N_CH-1:0] served_o,
  output logic            err_o
);

  localparam int CNT_W   = $clog2(N_CH) + 2;
  localparam int MAX_AD  = (ARM_CYC > DUMP_CYC) ? ARM_CYC : DUMP_CYC;
  localparam int MAX_CYC = (MAX_AD > GAP_CYC) ? MAX_AD : GAP_CYC;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] ARM_LAST  = TMR_W'(ARM_CYC - 1);
  localparam logic [TMR_W-1:0] DUMP_LAST = TMR_W'(DUMP_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(N_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_DUMP_HI  = 3'd2,
    S_DUMP_GAP = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            r_state;
  logic [TMR_W-1:0]  r_tmr;
  logic [CNT_W-1:0]  r_dump_cnt;
  logic [N_CH-1:0]   r_ch_sel;
  logic [N_CH-1:0]   r_served;
  logic              r_arm;
  logic              r_dump;
  logic              r_inter;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_err;
  logic              w_sel_ok;

  function automatic logic f_onehot(input logic [N_CH-1:0] v);
    return (v != '0) && ((v & (v - N_CH'(1))) == '0);
  endfunction

  // A report is accepted only if it names exactly one requested, not-yet-served channel
  assign w_sel_ok = f_onehot(ch_sel_i) &&
                    ((ch_sel_i & ~r_ch_sel) == '0) &&
                    ((ch_sel_i & r_served) == '0);

  // Frame sequencing state machine with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      r_dump_cnt   <= '0;
      r_ch_sel     <= '0;
      r_served     <= '0;
      r_arm        <= 1'b0;
      r_dump       <= 1'b0;
      r_inter      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_inter      <= 1'b0;
      r_frame_done <= 1'b0;
      if (abort_i && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_tmr   <= '0;
        r_arm   <= 1'b0;
        r_dump  <= 1'b0;
        r_inter <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_ch_sel   <= ch_mask_i;
              r_served   <= '0;
              r_err      <= 1'b0;
              r_tmr      <= '0;
              r_dump_cnt <= '0;
              r_busy     <= 1'b1;
              if (ch_mask_i != '0) begin
                r_state <= S_ARM;
                r_arm   <= 1'b1;
              end else begin
                r_state <= S_DONE;
              end
            end
          end
          S_ARM: begin
            if (r_tmr == ARM_LAST) begin
              r_state    <= S_DUMP_HI;
              r_tmr      <= '0;
              r_arm      <= 1'b0;
              r_dump     <= 1'b1;
              r_dump_cnt <= r_dump_cnt + CNT_W'(1);
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
          S_DUMP_HI: begin
            if (r_tmr == DUMP_LAST) begin
              r_state <= S_DUMP_GAP;
              r_tmr   <= '0;
              r_dump  <= 1'b0;
              if (w_sel_ok) begin
                r_served <= r_served | ch_sel_i;
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
          S_DUMP_GAP: begin
            if (r_tmr == GAP_LAST) begin
              r_tmr <= '0;
              if (cycle_done_i) begin
                r_state <= S_DONE;
              end else if (r_dump_cnt == CNT_LIMIT) begin
                // Responder never finished: give up without completing the frame
                r_state <= S_IDLE;
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state    <= S_DUMP_HI;
                r_dump     <= 1'b1;
                r_dump_cnt <= r_dump_cnt + CNT_W'(1);
              end
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
          S_DONE: begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            if (r_served != r_ch_sel) begin
              r_err <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_arm   <= 1'b0;
            r_dump  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch_sel_o     = r_ch_sel;
  assign served_o     = r_served;
  assign arm_o        = r_arm;
  assign dump_o       = r_dump;
  assign inter_o      = r_inter;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_dump_sequencer.sv
// Scenario bench for dump_sequencer (N_CH=4): per-cycle expected output words
// are queued as stimulus is driven and compared after each rising edge.
module tb_dump_sequencer;

  logic       clk_i;
  logic       rst_i;
  logic       start_i;
  logic [3:0] ch_mask_i;
  logic       abort_i;
  logic       cycle_done_i;
  logic [3:0] ch_sel_i;
  logic [3:0] ch_sel_o;
  logic       arm_o;
  logic       dump_o;
  logic       inter_o;
  logic       busy_o;
  logic       frame_done_o;
  logic [3:0] served_o;
  logic       err_o;

  logic [13:0] exp_q[$];
  logic [13:0] obs;
  int          n_vec;
  int          n_mis;

  dump_sequencer #(
    .N_CH(4), .ARM_CYC(2), .DUMP_CYC(2), .GAP_CYC(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ch_mask_i(ch_mask_i),
    .abort_i(abort_i), .cycle_done_i(cycle_done_i), .ch_sel_i(ch_sel_i),
    .ch_sel_o(ch_sel_o), .arm_o(arm_o), .dump_o(dump_o), .inter_o(inter_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .served_o(served_o), .err_o(err_o)
  );

  assign obs = {arm_o, dump_o, inter_o, busy_o, frame_done_o, err_o, served_o, ch_sel_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Expected word layout: arm, dump, inter, busy, frame_done, err, served[3:0], ch_sel[3:0]
  function automatic logic [13:0] mk(input logic a, input logic d, input logic it,
                                     input logic b, input logic f, input logic e,
                                     input logic [3:0] s, input logic [3:0] c);
    return {a, d, it, b, f, e, s, c};
  endfunction

  task automatic test_reset;
    logic [13:0] got, want;
    for (int i = 0; i < 2; i++) begin
      rst_i = 1'b1; start_i = 1'b1; abort_i = 1'b1; ch_mask_i = 4'b1111;
      cycle_done_i = 1'b1; ch_sel_i = 4'b0001;
      exp_q.push_back(14'd0);
      @(posedge clk_i); #1;
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++; $display("FAIL reset cyc%0d got=%b want=%b", i, got, want);
      end
    end
    rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; cycle_done_i = 1'b0; ch_sel_i = 4'b0000;
  endtask

  task automatic test_normal;
    logic [13:0] got, want;
    logic [3:0]  srv;
    for (int i = 0; i < 11; i++) begin
      start_i = (i == 0); ch_mask_i = 4'b1010; abort_i = 1'b0;
      cycle_done_i = (i == 8);
      ch_sel_i = (i < 6) ? 4'b0010 : 4'b1000;
      srv = (i < 4) ? 4'b0000 : ((i < 7) ? 4'b0010 : 4'b1010);
      exp_q.push_back(mk(i < 2, i == 2 || i == 3 || i == 5 || i == 6, 1'b0,
                         i < 9, i == 9, 1'b0, srv, 4'b1010));
      @(posedge clk_i); #1;
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++; $display("FAIL normal cyc%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_empty_mask;
    logic [13:0] got, want;
    for (int i = 0; i < 3; i++) begin
      start_i = (i == 0); ch_mask_i = 4'b0000; abort_i = 1'b0;
      cycle_done_i = 1'b0; ch_sel_i = 4'b0000;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, i == 0, i == 1, 1'b0, 4'b0000, 4'b0000));
      @(posedge clk_i); #1;
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++; $display("FAIL empty_mask cyc%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_dup_error;
    logic [13:0] got, want;
    logic [3:0]  srv;
    for (int i = 0; i < 13; i++) begin
      start_i = (i == 0 || i == 11); ch_mask_i = 4'b0011; abort_i = (i == 12);
      cycle_done_i = (i == 8); ch_sel_i = 4'b0001;
      srv = (i < 4 || i >= 11) ? 4'b0000 : 4'b0001;
      exp_q.push_back(mk(i < 2 || i == 11, i == 2 || i == 3 || i == 5 || i == 6, i == 12,
                         i < 9 || i == 11, i == 9, i >= 7 && i <= 10, srv, 4'b0011));
      @(posedge clk_i); #1;
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++; $display("FAIL dup_error cyc%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_watchdog;
    logic [13:0] got, want;
    logic [3:0]  srv, one;
    int          ix;
    one = 4'b0001;
    for (int i = 0; i < 19; i++) begin
      ix = (i >= 2) ? (i - 2) / 3 : 0;
      start_i = (i == 0); ch_mask_i = 4'b1111; abort_i = 1'b0; cycle_done_i = 1'b0;
      ch_sel_i = (i >= 2 && ix < 4) ? (one << ix) : 4'b0000;
      srv = (i < 4) ? 4'b0000 : (i < 7) ? 4'b0001 : (i < 10) ? 4'b0011 :
            (i < 13) ? 4'b0111 : 4'b1111;
      exp_q.push_back(mk(i < 2, i >= 2 && i < 17 && ((i - 2) % 3) != 2, 1'b0,
                         i < 17, 1'b0, i >= 16, srv, 4'b1111));
      @(posedge clk_i); #1;
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++; $display("FAIL watchdog cyc%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_abort;
    logic [13:0] got, want;
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 0 || i == 3); ch_mask_i = 4'b1010; abort_i = (i == 3);
      cycle_done_i = 1'b0; ch_sel_i = 4'b0010;
      exp_q.push_back(mk(i < 2, i == 2, i == 3, i < 3, 1'b0, 1'b0, 4'b0000, 4'b1010));
      @(posedge clk_i); #1;
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++; $display("FAIL abort cyc%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [13:0] got, want;
    int          j;
    for (int i = 0; i < 14; i++) begin
      j = i - 6;
      rst_i = (i == 5); start_i = (i == 0 || i == 6); abort_i = 1'b0;
      ch_mask_i = (i < 6) ? 4'b1010 : 4'b0100;
      ch_sel_i  = (i < 6) ? 4'b0010 : 4'b0100;
      cycle_done_i = (i == 11);
      if (i < 5)
        exp_q.push_back(mk(i < 2, i == 2 || i == 3, 1'b0, 1'b1, 1'b0, 1'b0,
                           (i == 4) ? 4'b0010 : 4'b0000, 4'b1010));
      else if (i == 5)
        exp_q.push_back(14'd0);
      else
        exp_q.push_back(mk(j < 2, j == 2 || j == 3, 1'b0, j < 6, j == 6, 1'b0,
                           (j >= 4) ? 4'b0100 : 4'b0000, 4'b0100));
      @(posedge clk_i); #1;
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++; $display("FAIL reset_mid cyc%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_mis = 0;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; ch_mask_i = 4'b0000;
    cycle_done_i = 1'b0; ch_sel_i = 4'b0000;
    test_reset();
    test_normal();
    test_empty_mask();
    test_dup_error();
    test_watchdog();
    test_abort();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
